gt_refclk_out_ctrl: RTL and testbench
=====================================

Name: gt_refclk_out_ctrl

Overview:
Sequencer for a GT differential reference-clock output buffer with a 4:1 recovered-clock source select and an active-low output enable (CEB).
- Guarantees glitch-free source changes: output disabled -> blanking wait -> select changed -> settle wait -> output re-enabled.
- Accepts enable/disable requests and source-change requests from a host via a valid/ready handshake.
- Sits between the host config logic and the buffer's CEB and RXRECCLK_SEL pins.

Parameters:
BLANK_CYCLES, 8, clk cycles CEB held high before select changes (min 1)
SETTLE_CYCLES, 16, clk cycles after select change before CEB drops (min 1)
CNT_W, 8, counter width; must hold max(BLANK_CYCLES, SETTLE_CYCLES)

Ports:
clk  in  1  single clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
en_req  in  1  level; 1 = host wants the output driven
sel_valid  in  1  source-change request valid
sel_data  in  2  requested source index 0..3
sel_ready  out  1  request accepted when sel_valid & sel_ready
ceb  out  1  to buffer CEB; 1 = output disabled
rxrecclk_sel  out  2  to buffer RXRECCLK_SEL
active  out  1  1 only in ON state (output stable and driven)
busy  out  1  1 in BLANK, SWITCH or SETTLE
switch_done  out  1  one-cycle pulse when a sequence completes

Behaviour:
Reset values: ceb=1, rxrecclk_sel=0, sel_ready=1, active=0, busy=0, switch_done=0; state OFF; pend_sel=0; counter=0.

States:
- OFF: ceb=1.
  - Handshake accepted -> rxrecclk_sel<=sel_data directly; no blanking needed because the output is already off; pulse switch_done.
  - en_req=1 with no handshake -> SETTLE (counter=SETTLE_CYCLES-1).
  - Handshake and en_req=1 in the same cycle -> apply the select, then SETTLE.
- ON: ceb=0, active=1.
  - Handshake accepted with sel_data != rxrecclk_sel -> latch pend_sel, go to BLANK (counter=BLANK_CYCLES-1), ceb=1 from the next cycle.
  - Handshake with sel_data == rxrecclk_sel -> accepted, stay in ON, pulse switch_done.
  - en_req=0 -> OFF, ceb=1 next cycle. en_req=0 takes priority over a simultaneous handshake; that request is accepted and applied as in OFF.
- BLANK: ceb=1; count down; at 0 -> SWITCH.
- SWITCH: one cycle; rxrecclk_sel<=pend_sel; -> SETTLE (counter=SETTLE_CYCLES-1).
- SETTLE: ceb=1; count down; at 0:
  - en_req=1 -> ON (ceb=0 next cycle), pulse switch_done.
  - en_req=0 -> OFF, pulse switch_done.

Handshake and output rules:
- sel_ready=1 in OFF and ON only; 0 in BLANK, SWITCH and SETTLE, so no mid-sequence request is ever lost or merged.
- en_req changes during BLANK, SWITCH or SETTLE are sampled only at SETTLE exit.
- rxrecclk_sel changes only while ceb=1 and has been 1 for at least BLANK_CYCLES cycles. The exception is OFF, where the output is already disabled.
- ceb falls only after rxrecclk_sel has been stable for at least SETTLE_CYCLES cycles.
- All outputs are registered; no combinational path from inputs to ceb or rxrecclk_sel.
- Latency ON -> ON, new source: ceb high for exactly BLANK_CYCLES+1+SETTLE_CYCLES cycles.

Reset mid-sequence: immediate return to reset values, ceb=1 asynchronously, pend_sel discarded.

Optional Feature:
Macro GT_REFCLK_CTRL_LOCK_EN.
- Defined: adds input lock_in (1 bit) and output lock_err (1 bit, reset 0).
  - SETTLE exits only when the counter is 0 and lock_in=1.
  - If lock_in is still 0 after a further 4*SETTLE_CYCLES cycles: go to OFF, set lock_err=1, pulse switch_done.
  - lock_err is sticky; it clears on the next accepted handshake or on reset.
- Undefined: no extra ports; SETTLE exits on the counter alone.

Test Plan:
- Reset, then en_req=1 (defaults) -> ceb stays 1 for 16 cycles then 0; active=1; rxrecclk_sel=0; switch_done pulses once.
- In ON, sel_valid=1, sel_data=2 -> ceb high exactly 25 cycles; rxrecclk_sel goes 0->2 on cycle 9 after ceb rises; back to ON; one switch_done pulse.
- In ON, request sel_data equal to current select -> accepted in 1 cycle; ceb never leaves 0; switch_done pulses.
- During BLANK, hold sel_valid=1, sel_data=3 -> sel_ready=0 throughout the sequence; the request is accepted on the first ON cycle and a second sequence runs to select 3.
- Assert reset_n=0 during SETTLE -> ceb=1 and rxrecclk_sel=0 immediately (asynchronously); after release, state OFF, active=0.
- GT_REFCLK_CTRL_LOCK_EN defined, lock_in held 0 -> after 16+64 cycles: state OFF, lock_err=1, ceb=1. Repeat with lock_in rising at cycle 30 -> ON at cycle 31, lock_err=0.

Source files
------------

// File: rtl/gt_refclk_out_ctrl.sv
// gt_refclk_out_ctrl
// Sequencer for a GT reference-clock output buffer. It drives the active-low
// buffer enable (ceb) and the 4:1 recovered-clock select (rxrecclk_sel).
// Every source change runs the same order: disable, blank, switch, settle,
// re-enable. That order keeps the buffer output free of glitches.
// Optional feature: define GT_REFCLK_CTRL_LOCK_EN to add lock_in/lock_err.
// With it, SETTLE also waits for lock, and gives up after a bounded timeout.

module gt_refclk_out_ctrl #(
  parameter int BLANK_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_req,
  input  logic       sel_valid,
  input  logic [1:0] sel_data,
`ifdef GT_REFCLK_CTRL_LOCK_EN
  input  logic       lock_in,
  output logic       lock_err,
`endif
  output logic       sel_ready,
  output logic       ceb,
  output logic [1:0] rxrecclk_sel,
  output logic       active,
  output logic       busy,
  output logic       switch_done
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ON,
    ST_BLANK,
    ST_SWITCH,
    ST_SETTLE
  } state_t;

  localparam logic [CNT_W-1:0] BLANK_LOAD  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       pend_sel;
  logic [CNT_W-1:0] cnt;
  logic             hs;
  logic             settle_ok;

`ifdef GT_REFCLK_CTRL_LOCK_EN
  localparam int              LOCK_TIMEOUT = 4 * SETTLE_CYCLES;
  localparam int              LOCK_W       = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_TIMEOUT);
  logic [LOCK_W-1:0] lock_cnt;
  assign settle_ok = lock_in;
`else
  assign settle_ok = 1'b1;
`endif

  assign hs = sel_valid & sel_ready;

  // Main sequencer: state, counter and every output are registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_OFF;
      ceb          <= 1'b1;
      rxrecclk_sel <= 2'd0;
      sel_ready    <= 1'b1;
      active       <= 1'b0;
      busy         <= 1'b0;
      switch_done  <= 1'b0;
      pend_sel     <= 2'd0;
      cnt          <= '0;
`ifdef GT_REFCLK_CTRL_LOCK_EN
      lock_cnt     <= '0;
      lock_err     <= 1'b0;
`endif
    end else begin
      switch_done <= 1'b0;
      case (state)
        ST_OFF: begin
          if (hs) begin
            rxrecclk_sel <= sel_data;
            switch_done  <= 1'b1;
`ifdef GT_REFCLK_CTRL_LOCK_EN
            lock_err     <= 1'b0;
`endif
          end
          if (en_req) begin
            state     <= ST_SETTLE;
            cnt       <= SETTLE_LOAD;
            sel_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef GT_REFCLK_CTRL_LOCK_EN
            lock_cnt  <= '0;
`endif
          end
        end

        ST_ON: begin
          if (!en_req) begin
            state  <= ST_OFF;
            ceb    <= 1'b1;
            active <= 1'b0;
            if (hs) begin
              rxrecclk_sel <= sel_data;
              switch_done  <= 1'b1;
`ifdef GT_REFCLK_CTRL_LOCK_EN
              lock_err     <= 1'b0;
`endif
            end
          end else if (hs) begin
`ifdef GT_REFCLK_CTRL_LOCK_EN
            lock_err <= 1'b0;
`endif
            if (sel_data != rxrecclk_sel) begin
              pend_sel  <= sel_data;
              state     <= ST_BLANK;
              cnt       <= BLANK_LOAD;
              ceb       <= 1'b1;
              active    <= 1'b0;
              busy      <= 1'b1;
              sel_ready <= 1'b0;
            end else begin
              switch_done <= 1'b1;
            end
          end
        end

        ST_BLANK: begin
          if (cnt == '0) begin
            state <= ST_SWITCH;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_SWITCH: begin
          rxrecclk_sel <= pend_sel;
          state        <= ST_SETTLE;
          cnt          <= SETTLE_LOAD;
`ifdef GT_REFCLK_CTRL_LOCK_EN
          lock_cnt     <= '0;
`endif
        end

        ST_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (settle_ok) begin
            state       <= en_req ? ST_ON : ST_OFF;
            ceb         <= ~en_req;
            active      <= en_req;
            busy        <= 1'b0;
            sel_ready   <= 1'b1;
            switch_done <= 1'b1;
`ifdef GT_REFCLK_CTRL_LOCK_EN
          end else if (lock_cnt == LOCK_LAST) begin
            state       <= ST_OFF;
            ceb         <= 1'b1;
            active      <= 1'b0;
            busy        <= 1'b0;
            sel_ready   <= 1'b1;
            switch_done <= 1'b1;
            lock_err    <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
`endif
          end
        end

        default: begin
          state     <= ST_OFF;
          ceb       <= 1'b1;
          active    <= 1'b0;
          busy      <= 1'b0;
          sel_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gt_refclk_out_ctrl.sv
// tb_gt_refclk_out_ctrl
// Directed bench for gt_refclk_out_ctrl with default parameters (8/16/8).
// Lock-feature tests are built only when GT_REFCLK_CTRL_LOCK_EN is defined.

module tb_gt_refclk_out_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en_req;
  logic       sel_valid;
  logic [1:0] sel_data;
  logic       sel_ready;
  logic       ceb;
  logic [1:0] rxrecclk_sel;
  logic       active;
  logic       busy;
  logic       switch_done;
`ifdef GT_REFCLK_CTRL_LOCK_EN
  logic       lock_in;
  logic       lock_err;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       v;
    logic [1:0] d;
    logic       e_ceb;
    logic [1:0] e_sel;
    logic       e_ready;
    logic       e_active;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[5];

  gt_refclk_out_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en_req       (en_req),
    .sel_valid    (sel_valid),
    .sel_data     (sel_data),
`ifdef GT_REFCLK_CTRL_LOCK_EN
    .lock_in      (lock_in),
    .lock_err     (lock_err),
`endif
    .sel_ready    (sel_ready),
    .ceb          (ceb),
    .rxrecclk_sel (rxrecclk_sel),
    .active       (active),
    .busy         (busy),
    .switch_done  (switch_done)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic v, input logic [1:0] d);
    en_req    = en;
    sel_valid = v;
    sel_data  = d;
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input string tag, input logic e_ceb, input logic [1:0] e_sel,
                              input logic e_ready, input logic e_active,
                              input logic e_busy, input logic e_done);
    chk({tag, ".ceb"},          {1'b0, ceb},         {1'b0, e_ceb});
    chk({tag, ".rxrecclk_sel"}, rxrecclk_sel,        e_sel);
    chk({tag, ".sel_ready"},    {1'b0, sel_ready},   {1'b0, e_ready});
    chk({tag, ".active"},       {1'b0, active},      {1'b0, e_active});
    chk({tag, ".busy"},         {1'b0, busy},        {1'b0, e_busy});
    chk({tag, ".switch_done"},  {1'b0, switch_done}, {1'b0, e_done});
  endtask

  // The caller has already driven the accepting request; this task runs the full
  // ON -> BLANK -> SWITCH -> SETTLE -> ON sequence, with ceb high for 25 cycles.
  task automatic run_switch(input string tag, input logic [1:0] old_sel,
                            input logic [1:0] new_sel, input logic nv,
                            input logic [1:0] nd);
    tick();
    check_output({tag, ".enter"}, 1'b1, old_sel, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, nv, nd);
    for (int i = 1; i <= 24; i++) begin
      tick();
      check_output($sformatf("%s.c%0d", tag, i), 1'b1,
                   (i >= 9) ? new_sel : old_sel, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    tick();
    check_output({tag, ".on"}, 1'b0, new_sel, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // OFF-state select changes: applied directly, each one pulses switch_done
    vecs[0] = '{en:1'b0, v:1'b1, d:2'd1, e_ceb:1'b1, e_sel:2'd1, e_ready:1'b1, e_active:1'b0, e_busy:1'b0, e_done:1'b1};
    vecs[1] = '{en:1'b0, v:1'b0, d:2'd2, e_ceb:1'b1, e_sel:2'd1, e_ready:1'b1, e_active:1'b0, e_busy:1'b0, e_done:1'b0};
    vecs[2] = '{en:1'b0, v:1'b1, d:2'd3, e_ceb:1'b1, e_sel:2'd3, e_ready:1'b1, e_active:1'b0, e_busy:1'b0, e_done:1'b1};
    vecs[3] = '{en:1'b0, v:1'b1, d:2'd0, e_ceb:1'b1, e_sel:2'd0, e_ready:1'b1, e_active:1'b0, e_busy:1'b0, e_done:1'b1};
    vecs[4] = '{en:1'b0, v:1'b0, d:2'd0, e_ceb:1'b1, e_sel:2'd0, e_ready:1'b1, e_active:1'b0, e_busy:1'b0, e_done:1'b0};

    reset_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 2'd0);
`ifdef GT_REFCLK_CTRL_LOCK_EN
    lock_in = 1'b1;
`endif
    #23;
    check_output("reset", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].en, vecs[i].v, vecs[i].d);
      tick();
      check_output($sformatf("vec%0d", i), vecs[i].e_ceb, vecs[i].e_sel, vecs[i].e_ready,
                   vecs[i].e_active, vecs[i].e_busy, vecs[i].e_done);
    end

    // Enable from OFF: ceb is high for 16 cycles, then the output is driven
    apply_stimulus(1'b1, 1'b0, 2'd0);
    tick();
    check_output("en.enter", 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check_output($sformatf("en.c%0d", i), 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    tick();
    check_output("en.on", 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check_output("en.hold", 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Switch 0 -> 2 from ON
    apply_stimulus(1'b1, 1'b1, 2'd2);
    run_switch("sw02", 2'd0, 2'd2, 1'b0, 2'd0);

    // Request equal to the current select: accepted at once, ceb stays low
    apply_stimulus(1'b1, 1'b1, 2'd2);
    tick();
    check_output("same", 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 2'd0);
    tick();
    check_output("same.after", 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    // A request held during a sequence waits, then starts a second sequence
    apply_stimulus(1'b1, 1'b1, 2'd1);
    run_switch("sw21", 2'd2, 2'd1, 1'b1, 2'd3);
    run_switch("sw13", 2'd1, 2'd3, 1'b0, 2'd0);

    // en_req=0 wins over a simultaneous request, which is still applied as in OFF
    apply_stimulus(1'b0, 1'b1, 2'd0);
    tick();
    check_output("prio", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 2'd0);
    tick();
    check_output("prio.after", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Select and enable together in OFF, then reset lands mid-SETTLE
    apply_stimulus(1'b1, 1'b1, 2'd2);
    tick();
    check_output("offen", 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b0, 2'd0);
    repeat (5) tick();
    check_output("offen.mid", 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check_output("async_rst", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 2'd0);
    #10;
    reset_n = 1'b1;
    tick();
    check_output("post_rst", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef GT_REFCLK_CTRL_LOCK_EN
    // No lock: 16 counted cycles plus 64 timeout cycles, then OFF with lock_err
    lock_in = 1'b0;
    apply_stimulus(1'b1, 1'b0, 2'd0);
    tick();
    check_output("lk.enter", 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 79; i++) begin
      tick();
      chk($sformatf("lk.c%0d.busy", i), {1'b0, busy}, 2'd1);
    end
    tick();
    check_output("lk.timeout", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("lk.lock_err_set", {1'b0, lock_err}, 2'd1);

    // Handshake clears lock_err; lock arrives late and the output comes up
    apply_stimulus(1'b1, 1'b1, 2'd0);
    tick();
    check_output("lk2.enter", 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("lk2.lock_err_clr", {1'b0, lock_err}, 2'd0);
    apply_stimulus(1'b1, 1'b0, 2'd0);
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk($sformatf("lk2.c%0d.ceb", i), {1'b0, ceb}, 2'd1);
    end
    lock_in = 1'b1;
    tick();
    check_output("lk2.on", 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("lk2.lock_err", {1'b0, lock_err}, 2'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
